// File: rtl/jt900h_simbus.sv
// Bus-side simulation model for the jt900h CPU: byte-laned RAM with wait states, interrupt
// countdown channels, stop/timeout detection and a register-dump sequencer.
// Optional bus checking is enabled by defining JT900H_SIMBUS_CHECK_EN.
module jt900h_simbus #(
    parameter int unsigned AW       = 12,
    parameter int unsigned WAIT     = 0,
    parameter int unsigned INTCH    = 2,
    parameter logic [23:0] INTBASE  = 24'hFFF0,
    parameter logic [23:0] STOPADDR = 24'hFFFF,
    parameter int unsigned TIMEOUT  = 100000,
    parameter int unsigned DUMPLEN  = 84
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [23:0] addr_i,
    input  logic [15:0] din_i,
    input  logic [1:0]  we_i,
    output logic [15:0] dout_o,
    output logic        rdy_o,
    output logic        cen_o,
    output logic [2:0]  intrq_o,
    output logic [7:0]  dmp_addr_o,
    input  logic [7:0]  dmp_din_i,
    input  logic [7:0]  buf_addr_i,
    output logic [7:0]  buf_dout_o,
    output logic        stop_o,
    output logic        tmo_o,
    output logic        done_o,
    output logic        err_o
);
    localparam int unsigned Words = 2 ** (AW - 1);

    typedef enum logic [1:0] {StRun, StDump, StDone} state_e;

    logic [15:0] mem [Words];
    logic [7:0]  dump_buf [256];

    state_e      state_q;
    logic [22:0] addr_q;
    logic [3:0]  wait_q;
    logic [31:0] cnt_q;
    logic        stop_q, tmo_q, done_q, cen_q;
    logic [2:0]  intrq_q;
    logic [7:0]  dmp_addr_q;

    logic [7:0]       ch_cnt_q [INTCH];
    logic [2:0]       ch_lvl_q [INTCH];
    logic [INTCH-1:0] ch_run_q, ch_pend_q;

    logic             run, rdy, wr_ok, mem_wr, new_access, stop_hit, stop_wr, tmo_hit;
    logic [INTCH-1:0] ch_hit;
    logic [2:0]       irq_lvl;
    logic [AW-2:0]    widx;
    logic             unused_addr0;

    assign unused_addr0 = addr_i[0];

    function automatic logic [22:0] ch_word(int unsigned n);
        return INTBASE[23:1] + 23'(n);
    endfunction

`ifdef JT900H_SIMBUS_CHECK_EN
    logic       in_range, reg_hit, err_q;
    logic [1:0] we_q;
    assign in_range = (addr_i[23:AW] == '0);
    assign reg_hit  = (|ch_hit) | stop_hit;
    // Out-of-range accesses that miss every register are dropped instead of aliased.
    assign mem_wr   = wr_ok && (in_range || reg_hit);
`else
    assign mem_wr   = wr_ok;
`endif

    assign run        = (state_q == StRun);
    assign rdy        = (wait_q == 4'd0);
    assign wr_ok      = rdy && (we_i != 2'b00) && run;
    assign new_access = (addr_i[23:1] != addr_q) || wr_ok;
    assign stop_hit   = (addr_i[23:1] == STOPADDR[23:1]);
    assign stop_wr    = wr_ok && we_i[1] && stop_hit;
    assign tmo_hit    = (TIMEOUT != 0) && run && ((cnt_q + 32'd1) == TIMEOUT);
    assign widx       = addr_i[AW-1:1];

    always_comb begin
        ch_hit  = '0;
        irq_lvl = 3'd0;
        for (int unsigned n = 0; n < INTCH; n++) begin
            ch_hit[n] = (addr_i[23:1] == ch_word(n));
            if (ch_pend_q[n] && (ch_lvl_q[n] > irq_lvl)) irq_lvl = ch_lvl_q[n];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StRun;
            addr_q     <= '0;
            wait_q     <= 4'(WAIT);
            cnt_q      <= '0;
            stop_q     <= 1'b0;
            tmo_q      <= 1'b0;
            done_q     <= 1'b0;
            cen_q      <= 1'b1;
            intrq_q    <= 3'd0;
            dmp_addr_q <= 8'd0;
            ch_run_q   <= '0;
            ch_pend_q  <= '0;
            for (int unsigned n = 0; n < INTCH; n++) begin
                ch_cnt_q[n] <= 8'd0;
                ch_lvl_q[n] <= 3'd0;
            end
        end else begin
            addr_q <= addr_i[23:1];
            if (new_access) wait_q <= 4'(WAIT);
            else if (wait_q != 4'd0) wait_q <= wait_q - 4'd1;
            if (run) cnt_q <= cnt_q + 32'd1;

            // A register write takes priority over a same-cycle expiry.
            for (int unsigned n = 0; n < INTCH; n++) begin
                if (wr_ok && we_i[0] && ch_hit[n]) begin
                    ch_cnt_q[n] <= din_i[15:8];
                    ch_lvl_q[n] <= din_i[2:0];
                    ch_run_q[n] <= (din_i[15:8] != 8'd0);
                    if (din_i[15:8] == 8'd0) ch_pend_q[n] <= 1'b0;
                end else if (ch_run_q[n] && cen_q) begin
                    ch_cnt_q[n] <= ch_cnt_q[n] - 8'd1;
                    if (ch_cnt_q[n] == 8'd1) begin
                        ch_pend_q[n] <= 1'b1;
                        ch_run_q[n]  <= 1'b0;
                    end
                end
            end
            intrq_q <= irq_lvl;

            unique case (state_q)
                StRun: begin
                    if (stop_wr || tmo_hit) begin
                        stop_q     <= 1'b1;
                        tmo_q      <= !stop_wr;
                        cen_q      <= 1'b0;
                        dmp_addr_q <= 8'd0;
                        state_q    <= StDump;
                    end
                end
                StDump: begin
                    if (dmp_addr_q == 8'(DUMPLEN)) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        dmp_addr_q <= dmp_addr_q + 8'd1;
                    end
                end
                StDone: ;
                default: state_q <= StRun;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_wr) begin
            if (we_i[0]) mem[widx][7:0]  <= din_i[7:0];
            if (we_i[1]) mem[widx][15:8] <= din_i[15:8];
        end
    end

    // The CPU returns dump data one cycle after the address, so slot 0 is skipped.
    always_ff @(posedge clk_i) begin
        if ((state_q == StDump) && (dmp_addr_q != 8'd0)) begin
            dump_buf[dmp_addr_q - 8'd1] <= dmp_din_i;
        end
    end

`ifdef JT900H_SIMBUS_CHECK_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
            we_q  <= 2'b00;
        end else begin
            we_q <= we_i;
            if (rdy && run && !in_range && !reg_hit) err_q <= 1'b1;
            if (!rdy && (we_i != we_q)) err_q <= 1'b1;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign dout_o     = mem[widx];
    assign buf_dout_o = dump_buf[buf_addr_i];
    assign rdy_o      = rdy;
    assign cen_o      = cen_q;
    assign intrq_o    = intrq_q;
    assign dmp_addr_o = dmp_addr_q;
    assign stop_o     = stop_q;
    assign tmo_o      = tmo_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_jt900h_simbus.sv
// Directed bench for jt900h_simbus: u0 uses no wait states and no timeout, u1 uses WAIT=2 and
// TIMEOUT=50. Expected read data and dump bytes flow through a scoreboard queue.
module tb_jt900h_simbus;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        rst0, rst1;
    logic [23:0] addr0, addr1;
    logic [15:0] din0, din1, dout0, dout1;
    logic [1:0]  we0, we1;
    logic        rdy0, rdy1, cen0, cen1, stop0, stop1, tmo0, tmo1, done0, done1, err0, err1;
    logic [2:0]  intrq0, intrq1;
    logic [7:0]  dmp_addr0, dmp_addr1, dmp_din0, dmp_din1;
    logic [7:0]  buf_addr0, buf_addr1, buf_dout0, buf_dout1;

    logic [15:0] exp_q [$];
    logic [15:0] ref0 [int];
    logic [15:0] ref1 [int];

    jt900h_simbus #(.AW(12), .WAIT(0), .INTCH(2), .TIMEOUT(0), .DUMPLEN(84)) u0 (
        .clk_i(clk), .rst_i(rst0), .addr_i(addr0), .din_i(din0), .we_i(we0), .dout_o(dout0),
        .rdy_o(rdy0), .cen_o(cen0), .intrq_o(intrq0), .dmp_addr_o(dmp_addr0),
        .dmp_din_i(dmp_din0), .buf_addr_i(buf_addr0), .buf_dout_o(buf_dout0), .stop_o(stop0),
        .tmo_o(tmo0), .done_o(done0), .err_o(err0)
    );

    jt900h_simbus #(.AW(12), .WAIT(2), .INTCH(2), .TIMEOUT(50), .DUMPLEN(84)) u1 (
        .clk_i(clk), .rst_i(rst1), .addr_i(addr1), .din_i(din1), .we_i(we1), .dout_o(dout1),
        .rdy_o(rdy1), .cen_o(cen1), .intrq_o(intrq1), .dmp_addr_o(dmp_addr1),
        .dmp_din_i(dmp_din1), .buf_addr_i(buf_addr1), .buf_dout_o(buf_dout1), .stop_o(stop1),
        .tmo_o(tmo1), .done_o(done1), .err_o(err1)
    );

    // CPU dump port: data for an address appears one cycle later.
    always @(posedge clk) begin
        dmp_din0 <= dmp_addr0 ^ 8'h5A;
        dmp_din1 <= dmp_addr1 ^ 8'h5A;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] d,
                                          input logic [1:0] w);
        return {w[1] ? d[15:8] : o[15:8], w[0] ? d[7:0] : o[7:0]};
    endfunction

    task automatic wr0(input logic [23:0] a, input logic [15:0] d, input logic [1:0] w,
                       input bit upd);
        int idx;
        addr0 = a; din0 = d; we0 = w;
        @(negedge clk);
        we0 = 2'b00;
        if (upd) begin
            idx = int'(a[11:1]);
            ref0[idx] = merge(ref0.exists(idx) ? ref0[idx] : 16'h0000, d, w);
        end
    endtask

    task automatic rd0(input logic [23:0] a, input string tag);
        addr0 = a;
        #1;
        exp_q.push_back(ref0[int'(a[11:1])]);
        chk(tag, 32'(dout0), 32'(exp_q.pop_front()));
    endtask

    task automatic wait_rdy1(input string tag);
        int n = 0;
        while (!rdy1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk(tag, 32'(rdy1), 32'd1);
    endtask

    task automatic wr1(input logic [23:0] a, input logic [15:0] d, input logic [1:0] w);
        int idx;
        addr1 = a; din1 = d; we1 = w;
        wait_rdy1("wr1_rdy_timeout");
        @(negedge clk);
        we1 = 2'b00;
        idx = int'(a[11:1]);
        ref1[idx] = merge(ref1.exists(idx) ? ref1[idx] : 16'h0000, d, w);
    endtask

    task automatic wait_done(input bit sel, input string tag);
        int n = 0;
        while (!(sel ? done1 : done0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(sel ? done1 : done0), 32'd1);
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        addr0 = '0; din0 = '0; we0 = '0; buf_addr0 = '0;
        addr1 = '0; din1 = '0; we1 = '0; buf_addr1 = '0;
        repeat (3) @(negedge clk);
        rst0 = 1'b0;
        @(negedge clk);

        chk("rst_cen", 32'(cen0), 32'd1);
        chk("rst_rdy", 32'(rdy0), 32'd1);
        chk("rst_intrq", 32'(intrq0), 32'd0);
        chk("rst_stop", 32'(stop0), 32'd0);
        chk("rst_tmo", 32'(tmo0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_err", 32'(err0), 32'd0);
        chk("rst_dmp_addr", 32'(dmp_addr0), 32'd0);
        chk("rst_rdy_wait2", 32'(rdy1), 32'd0);

        // Byte lanes
        wr0(24'h000010, 16'hABCD, 2'b11, 1'b1);
        wr0(24'h000010, 16'h1234, 2'b01, 1'b1);
        rd0(24'h000010, "lane_lo");
        chk("lane_lo_const", 32'(dout0), 32'h0000AB34);
        wr0(24'h000011, 16'h5600, 2'b10, 1'b1);
        rd0(24'h000011, "lane_hi");
        wr0(24'h000000, 16'h1111, 2'b11, 1'b1);
        wr0(24'h000020, 16'h2222, 2'b11, 1'b1);
`ifdef JT900H_SIMBUS_CHECK_EN
        wr0(24'h010000, 16'hBEEF, 2'b11, 1'b0);
        rd0(24'h000000, "oob_dropped");
        chk("oob_err", 32'(err0), 32'd1);
`else
        wr0(24'h001020, 16'h7777, 2'b11, 1'b1);
        rd0(24'h000020, "alias");
        rd0(24'h000000, "alias_other");
        chk("err_tied", 32'(err0), 32'd0);
`endif

        // Single channel countdown
        @(negedge clk);
        wr0(24'h00FFF0, 16'h0503, 2'b11, 1'b1);
        repeat (5) @(negedge clk);
        chk("irq_early", 32'(intrq0), 32'd0);
        @(negedge clk);
        chk("irq_lvl3", 32'(intrq0), 32'd3);
        wr0(24'h00FFF0, 16'h0000, 2'b11, 1'b1);
        @(negedge clk);
        chk("irq_clear", 32'(intrq0), 32'd0);
        rd0(24'h00FFF0, "reg_ram");
        @(negedge clk);

        // Two channels, max level wins
        wr0(24'h00FFF0, 16'h0302, 2'b11, 1'b1);
        wr0(24'h00FFF2, 16'h0205, 2'b11, 1'b1);
        repeat (6) @(negedge clk);
        chk("irq_max", 32'(intrq0), 32'd5);
        wr0(24'h00FFF2, 16'h0000, 2'b11, 1'b1);
        @(negedge clk);
        chk("irq_ch1_clr", 32'(intrq0), 32'd2);
        wr0(24'h00FFF0, 16'h0000, 2'b11, 1'b1);
        @(negedge clk);
        chk("irq_ch0_clr", 32'(intrq0), 32'd0);

        // Reload on the expiry cycle
        wr0(24'h00FFF0, 16'h0302, 2'b11, 1'b1);
        repeat (2) @(negedge clk);
        wr0(24'h00FFF0, 16'h0302, 2'b11, 1'b1);
        repeat (3) @(negedge clk);
        chk("reload_wins", 32'(intrq0), 32'd0);
        @(negedge clk);
        chk("reload_expire", 32'(intrq0), 32'd2);
        wr0(24'h00FFF0, 16'h0000, 2'b11, 1'b1);

        // Stop write and dump
        wr0(24'h00FFFF, 16'hAA00, 2'b10, 1'b1);
        chk("stop_set", 32'(stop0), 32'd1);
        chk("stop_cen", 32'(cen0), 32'd0);
        chk("stop_tmo", 32'(tmo0), 32'd0);
        chk("dump_start", 32'(dmp_addr0), 32'd0);
        @(negedge clk);
        chk("dump_incr", 32'(dmp_addr0), 32'd1);
        wait_done(1'b0, "dump_done");
        chk("dump_last", 32'(dmp_addr0), 32'd84);
        chk("done_cen", 32'(cen0), 32'd0);
        for (int i = 0; i < 84; i++) exp_q.push_back(16'(8'(i) ^ 8'h5A));
        for (int i = 0; i < 84; i++) begin
            buf_addr0 = 8'(i);
            #1;
            chk("dump_buf", 32'(buf_dout0), 32'(exp_q.pop_front()));
        end
        @(negedge clk);
        wr0(24'h000010, 16'hFFFF, 2'b11, 1'b0);
        rd0(24'h000010, "done_frozen");

        // Wait states on u1
        rst1 = 1'b0;
        @(negedge clk);
        chk("w_rst_1", 32'(rdy1), 32'd0);
        @(negedge clk);
        chk("w_rst_2", 32'(rdy1), 32'd1);
        wr1(24'h000800, 16'h00FF, 2'b11);
        wr1(24'h000802, 16'h01FE, 2'b11);
        addr1 = 24'h000000;
        @(negedge clk);
        wait_rdy1("idle_rdy_timeout");
        addr1 = 24'h000800;
        @(negedge clk);
        chk("wait_a1", 32'(rdy1), 32'd0);
        @(negedge clk);
        chk("wait_a2", 32'(rdy1), 32'd0);
        @(negedge clk);
        chk("wait_a3", 32'(rdy1), 32'd1);
        exp_q.push_back(ref1[int'(addr1[11:1])]);
        chk("rd_800", 32'(dout1), 32'(exp_q.pop_front()));
        addr1 = 24'h000802;
        @(negedge clk);
        chk("wait_b1", 32'(rdy1), 32'd0);
        @(negedge clk);
        chk("wait_b2", 32'(rdy1), 32'd0);
        @(negedge clk);
        chk("wait_b3", 32'(rdy1), 32'd1);
        exp_q.push_back(ref1[int'(addr1[11:1])]);
        chk("rd_802", 32'(dout1), 32'(exp_q.pop_front()));

        // Timeout on u1
        addr1 = 24'h000000;
        rst1 = 1'b1;
        repeat (2) @(negedge clk);
        rst1 = 1'b0;
        repeat (49) @(negedge clk);
        chk("tmo_before", 32'(stop1), 32'd0);
        @(negedge clk);
        chk("tmo_stop", 32'(stop1), 32'd1);
        chk("tmo_flag", 32'(tmo1), 32'd1);
        chk("tmo_cen", 32'(cen1), 32'd0);
        wait_done(1'b1, "tmo_dump_done");
        chk("tmo_dump_last", 32'(dmp_addr1), 32'd84);
        exp_q.push_back(16'h005A);
        exp_q.push_back(16'(8'd83 ^ 8'h5A));
        buf_addr1 = 8'd0;
        #1;
        chk("tmo_buf0", 32'(buf_dout1), 32'(exp_q.pop_front()));
        buf_addr1 = 8'd83;
        #1;
        chk("tmo_buf83", 32'(buf_dout1), 32'(exp_q.pop_front()));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/jt900h_simbus.md
Name: jt900h_simbus

Overview:
- Parametrised bus-side model for the jt900h CPU in system-level benches; successor to the fixed 16-bit RAM plus interrupt/stop glue.
- Provides 16-bit byte-laned RAM with programmable wait states, INTCH independent interrupt countdown channels, stop/timeout detection, and a register-dump sequencer.
- Sits between the CPU bus/dump ports and the bench.
- Synthesizable except for memory initialisation.

Parameters:
- AW, 12, byte-address bits decoded for RAM; the RAM holds 2^(AW-1) 16-bit words.
- WAIT, 0, wait cycles inserted per new access (0..15).
- INTCH, 2, interrupt channels (1..4).
- INTBASE, 24'hFFF0, byte address of channel 0; channel n is at INTBASE+2n.
- STOPADDR, 24'hFFFF, address whose upper-byte write stops the run.
- TIMEOUT, 100000, cycles after reset before a forced stop; 0 disables it.
- DUMPLEN, 84, bytes read from the CPU dump port.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- addr  in  24  CPU byte address
- din  in  16  CPU write data
- we  in  2  byte write enables [1]=upper, [0]=lower
- dout  out  16  read data
- rdy  out  1  access complete
- cen  out  1  CPU clock enable
- intrq  out  3  interrupt level to CPU
- dmp_addr  out  8  CPU dump-port address
- dmp_din  in  8  CPU dump-port data
- buf_addr  in  8  bench read index into dump buffer
- buf_dout  out  8  dump buffer byte
- stop  out  1  sticky: stop write seen or timeout
- tmo  out  1  sticky: stop caused by timeout
- done  out  1  dump complete
- err  out  1  bus error flag (see Optional Feature)

Behaviour:
- Reset values: cen=1, rdy=(WAIT==0), intrq=0, stop=0, tmo=0, done=0, err=0, dmp_addr=0, all channels idle, cycle counter 0, FSM=RUN. RAM and dump buffer contents are not reset.
- Read path:
  - dout = mem[addr[AW-1:1]], combinational. Upper byte is at odd address.
- Wait states:
  - A new access is any cycle where addr[23:1] differs from the value registered in the previous cycle, or a write is accepted.
  - On a new access the wait counter loads WAIT and rdy drops for WAIT cycles.
  - WAIT=0 means rdy is constantly 1.
- Writes:
  - A write commits on the rising edge when rdy=1 and we!=0.
  - Lanes merge per we bit; unselected lanes keep their old value.
  - Addresses outside the RAM range alias modulo 2^AW.
- Interrupt channel n (register write with we[0]):
  - Count is loaded from din[15:8] and level from din[2:0].
  - A written count of 0 clears the channel's pending state and stops it.
  - A running channel decrements every clk cycle while cen=1. The cycle it reaches 0 it becomes pending with its level.
  - intrq is registered: the maximum level across pending channels, or 0 if none is pending.
  - Reload and expiry in the same cycle: the reload wins and nothing becomes pending.
  - Register writes also update RAM.
- Stop:
  - A committed write to STOPADDR with we[1]=1 sets stop.
  - Alternatively the cycle counter reaching TIMEOUT sets stop and tmo.
  - Both in the same cycle: stop=1, tmo=0.
- FSM RUN -> DUMP on stop rising.
- DUMP:
  - cen=0. dmp_addr increments every cycle from 0.
  - Buffer[dmp_addr-1] <= dmp_din (one-cycle CPU latency); the first cycle is discarded.
  - After capturing byte DUMPLEN-1 (dmp_addr==DUMPLEN) -> DONE.
- DONE:
  - done=1, cen stays 0, dmp_addr holds.
  - Writes and interrupt counting are frozen.
- Always: buf_dout = buffer[buf_addr], combinational.
- rst mid-DUMP returns the FSM to RUN, clears stop/tmo/done and leaves the buffer contents undefined.

Optional Feature:
- Macro JT900H_SIMBUS_CHECK_EN.
- Defined:
  - err is set (sticky) on any committed write or read with addr[23:AW]!=0 that does not hit a channel register or STOPADDR.
  - Such writes are dropped rather than aliased.
  - err is also set if we changes while rdy=0.
- Undefined: err is tied 0 and out-of-range accesses alias.

Test Plan:
- WAIT=2: read 0x800 then 0x802 -> rdy low 2 cycles after each address change; dout=0x00FF, then 0x01FE after preload.
- Byte write: we=2'b01, din=0x1234 to a word holding 0xABCD -> word reads 0xAB34.
- Channel 0 write 0x0503 with no other channel pending -> intrq=3 exactly 5 cycles after commit (+1 register cycle). Then write 0x0000 -> intrq=0 next cycle.
- Channel 0 level 2, channel 1 level 5 both pending -> intrq=5. Clear channel 1 -> intrq=2. Reload channel 0 on its expiry cycle -> no pending.
- Write 0xAA00 with we=2'b10 to 0xFFFF -> stop=1, cen=0; dmp_addr 0..84 driven from CPU with byte=addr^0x5A; done=1; buf[i]=i^0x5A for i=0..83.
- TIMEOUT=50 with no stop write -> stop=tmo=1 at cycle 50, dump completes. With CHECK_EN, a write to 0x010000 sets err and leaves mem[0] unchanged.
